fma_issue_ctrl: RTL and testbench
=================================

# fma_issue_ctrl

Issue and retire controller that wraps the fixed-latency, non-stallable fused multiply-add pipeline. It accepts operations on a valid/ready interface and registers operands into the FMA. It tracks in-flight operations with a valid/tag shift register matched to the FMA depth. Results are captured into a result FIFO and presented on a valid/ready output, so downstream backpressure never drops a result. Credit accounting guarantees the FIFO cannot overflow even though the FMA itself cannot stall.

## Interface
- FW, 23, fraction width of operands/result
- EW, 8, exponent width
- LAT, 5, FMA pipeline depth: cycles from FMA input sampling to valid `fma_result`
- TAGW, 5, tag width carried alongside each operation
- DEPTH, 8, result FIFO entries; must be ≥ 1; DEPTH ≥ LAT+2 gives one op/cycle sustained
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  synchronous kill of all in-flight and buffered operations
- in_valid  in  1  operation request
- in_ready  out  1  controller accepts request this cycle
- in_rm  in  3  rounding mode
- in_op  in  4  FMA operation code
- in_a, in_b, in_c  in  EW+FW+1 each  operands
- in_tag  in  TAGW  opaque tag returned with result
- fma_rm  out  3  registered rounding mode to FMA
- fma_op  out  4  registered op code to FMA
- fma_opA, fma_opB, fma_opC  out  EW+FW+1 each  registered operands to FMA
- fma_result  in  EW+FW+1  FMA result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  EW+FW+1  result at FIFO head
- out_tag  out  TAGW  tag at FIFO head
- busy  out  1  occ ≠ 0

## Operation
- **Occupancy `occ`** (width $clog2(DEPTH+1)): covers ops in the issue register, in the shift register, and in the FIFO.
  - +1 on fire (`in_valid & in_ready`), −1 on pop (`out_valid & out_ready`); both in one cycle → unchanged.
- `in_ready = (occ < DEPTH) & ~flush`. It is derived from registered state only and has no combinational path from `out_ready`.
- **Issue register:** on fire, `fma_rm/op/opA/B/C` load `in_*`. They hold their value when there is no fire.
- **Shift register:** `vld[0..LAT]` with `tag[0..LAT]`.
  - `vld[0]` and `tag[0]` load with the issue register; `vld[0]` = fire.
  - Each stage shifts every cycle unconditionally.
  - `vld[LAT]` is high exactly in the cycle `fma_result` belongs to that op.
- **FIFO write:** when `vld[LAT]` is high, `{fma_result, tag[LAT]}` is written at the clock edge. The FIFO is registered, not fall-through.
  - A write to a full FIFO is impossible by construction; a simulation assertion must flag it.
- **FIFO read:** `out_result/out_tag` show the head; `out_valid` = FIFO non-empty. Pointers wrap modulo DEPTH. Simultaneous write and read at full or empty is legal.
- **Ordering:** results retire in issue order; tags are never reordered.
- **flush:** at the edge, clears `vld[*]`, FIFO pointers/count and `occ`.
  - No fire is accepted in a flush cycle.
  - A pop during a flush cycle is discarded, not counted.
  - `fma_*` registers are not cleared.
- **Reset** (`rst_n`=0 at edge): same effect as flush, and additionally `fma_*` registers go to 0. Reset mid-operation discards everything without producing any output.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 after; `out_valid`=0, `busy`=0; `fma_*`=0; `out_result/out_tag` are don't-care while `out_valid`=0.
- Fire in cycle t → FMA inputs valid in cycle t+1 → `vld[LAT]` high in cycle t+1+LAT → `out_valid` in cycle t+2+LAT (FIFO empty). Fire-to-result latency is LAT+2.
- Throughput is 1 op/cycle when `out_ready`=1 and DEPTH ≥ LAT+2.
- After flush or reset, `out_valid`=0 and `busy`=0 from the next cycle.

## Test plan
- **Single op:** `in_a`=0x3FC00000, `in_b`=0x40000000, `in_c`=0x3E800000, FMADD op, rm=000, tag=3 at cycle 0 → `out_valid` at cycle LAT+2=7 with `out_result`=0x40500000, `out_tag`=3; `busy` 1→0 after pop.
- **Back-to-back:** 20 ops, tags 0..19, `out_ready`=1 → `in_ready` never drops; results cycles 7..26, tags in order.
- **Backpressure:** `out_ready`=0, `in_valid`=1 continuously → exactly 8 fires, then `in_ready`=0. Raising `out_ready` drains 8 results in tag order, and `in_ready` returns the cycle after the first pop.
- **Simultaneous at boundary:** `occ`=7 with fire and pop in the same cycle → `occ` stays 7, `in_ready` stays 1. At `occ`=8, a pop alone → `in_ready`=1 next cycle.
- **Flush mid-flight:** 3 ops issued, flush at cycle 4 → no `out_valid` ever for them. A new op at cycle 5 returns at cycle 12 with its own tag.
- **Reset mid-operation:** `rst_n`=0 for one cycle with 5 in flight and 2 buffered → no outputs afterward, `fma_*`=0, `busy`=0; the next op completes normally with latency 7.

Source files
------------

// File: rtl/fma_issue_ctrl_if.sv
// fma_issue_ctrl_if: request and result valid/ready bundle between a client and fma_issue_ctrl
interface fma_issue_ctrl_if #(
    parameter int FW   = 23,
    parameter int EW   = 8,
    parameter int TAGW = 5
);
    localparam int W = EW + FW + 1;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_rm;
    logic [3:0]      in_op;
    logic [W-1:0]    in_a, in_b, in_c;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_result;
    logic [TAGW-1:0] out_tag;
    modport master (
        output in_valid, in_rm, in_op, in_a, in_b, in_c, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );
    modport slave (
        input  in_valid, in_rm, in_op, in_a, in_b, in_c, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: issues ops into a fixed-latency FMA and retires results in order through a credited FIFO
module fma_issue_ctrl #(
    parameter int FW    = 23,
    parameter int EW    = 8,
    parameter int LAT   = 5,
    parameter int TAGW  = 5,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    fma_issue_ctrl_if.slave   io,
    output logic [2:0]        fma_rm,
    output logic [3:0]        fma_op,
    output logic [EW+FW:0]    fma_opA,
    output logic [EW+FW:0]    fma_opB,
    output logic [EW+FW:0]    fma_opC,
    input  logic [EW+FW:0]    fma_result,
    output logic              busy
);
    localparam int W  = EW + FW + 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [OW-1:0]   occ_q, occ_d, cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LAT:0]    vld_q, vld_d;
    logic [TAGW-1:0] tag_q [LAT+1];
    logic [TAGW-1:0] tag_d [LAT+1];
    logic [W-1:0]    res_mem_q [DEPTH];
    logic [W-1:0]    res_mem_d [DEPTH];
    logic [TAGW-1:0] tag_mem_q [DEPTH];
    logic [TAGW-1:0] tag_mem_d [DEPTH];
    logic [2:0]      fma_rm_q, fma_rm_d;
    logic [3:0]      fma_op_q, fma_op_d;
    logic [W-1:0]    fma_a_q, fma_a_d, fma_b_q, fma_b_d, fma_c_q, fma_c_d;
    logic            fire, pop, wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // occ counts every op from acceptance until popped, so it bounds FIFO fill
    assign io.in_ready   = rst_n & ~flush & (occ_q < OW'(DEPTH));
    assign io.out_valid  = cnt_q != '0;
    assign io.out_result = res_mem_q[rd_q];
    assign io.out_tag    = tag_mem_q[rd_q];
    assign fire          = io.in_valid & io.in_ready;
    assign pop           = io.out_valid & io.out_ready & ~flush;
    assign wr            = vld_q[LAT] & ~flush;
    assign busy          = occ_q != '0;
    assign fma_rm        = fma_rm_q;
    assign fma_op        = fma_op_q;
    assign fma_opA       = fma_a_q;
    assign fma_opB       = fma_b_q;
    assign fma_opC       = fma_c_q;

    always_comb begin
        occ_d    = flush ? '0 : occ_q + OW'(fire) - OW'(pop);
        cnt_d    = flush ? '0 : cnt_q + OW'(wr) - OW'(pop);
        wr_d     = flush ? '0 : (wr ? nxt(wr_q) : wr_q);
        rd_d     = flush ? '0 : (pop ? nxt(rd_q) : rd_q);
        vld_d    = flush ? '0 : {vld_q[LAT-1:0], fire};
        fma_rm_d = fire ? io.in_rm : fma_rm_q;
        fma_op_d = fire ? io.in_op : fma_op_q;
        fma_a_d  = fire ? io.in_a : fma_a_q;
        fma_b_d  = fire ? io.in_b : fma_b_q;
        fma_c_d  = fire ? io.in_c : fma_c_q;
        tag_d[0] = fire ? io.in_tag : tag_q[0];
        for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
        res_mem_d = res_mem_q;
        tag_mem_d = tag_mem_q;
        if (wr) begin
            res_mem_d[wr_q] = fma_result;
            tag_mem_d[wr_q] = tag_q[LAT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            vld_q    <= '0;
            fma_rm_q <= '0;
            fma_op_q <= '0;
            fma_a_q  <= '0;
            fma_b_q  <= '0;
            fma_c_q  <= '0;
        end else begin
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            vld_q    <= vld_d;
            fma_rm_q <= fma_rm_d;
            fma_op_q <= fma_op_d;
            fma_a_q  <= fma_a_d;
            fma_b_q  <= fma_b_d;
            fma_c_q  <= fma_c_d;
        end
        tag_q     <= tag_d;
        res_mem_q <= res_mem_d;
        tag_mem_q <= tag_mem_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (rst_n && wr && !pop) assert (cnt_q != OW'(DEPTH)) else $error("result fifo overflow");
`endif
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// tb_fma_issue_ctrl: directed, table and random checks of fma_issue_ctrl against a queue-based model
module tb_fma_issue_ctrl;
    localparam int FW = 23, EW = 8, LAT = 5, TAGW = 5, DEPTH = 8;
    localparam int W = EW + FW + 1;

    logic clk = 0;
    logic rst_n = 0;
    logic flush = 0;
    logic [2:0] fma_rm;
    logic [3:0] fma_op;
    logic [W-1:0] fma_opA, fma_opB, fma_opC, fma_result;
    logic busy;
    int errors = 0, checks = 0, cyc = 0;
    bit mon_en = 0;

    fma_issue_ctrl_if #(.FW(FW), .EW(EW), .TAGW(TAGW)) io();

    fma_issue_ctrl #(.FW(FW), .EW(EW), .LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .io(io),
        .fma_rm(fma_rm), .fma_op(fma_op), .fma_opA(fma_opA), .fma_opB(fma_opB),
        .fma_opC(fma_opC), .fma_result(fma_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // FMA stand-in: a*b+c, with rm/op folded in so the issued control fields are observable
    function automatic logic [31:0] fma_ref(input logic [31:0] a, b, c, input logic [2:0] rm, input logic [3:0] op);
        return r2f(f2r(a) * f2r(b) + f2r(c)) ^ {25'd0, rm, op};
    endfunction

    function automatic logic [31:0] rnd();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    logic [W-1:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= fma_ref(fma_opA, fma_opB, fma_opC, fma_rm, fma_op);
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fma_result = fpipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [W-1:0] res; logic [TAGW-1:0] tag; int rdy; } ent_t;
    ent_t q[$];

    // every accepted op becomes visible LAT+2 cycles later and leaves in acceptance order
    always @(negedge clk) if (mon_en) begin : model
        bit ev, er;
        er = rst_n && !flush && q.size() < DEPTH;
        ev = q.size() > 0 && q[0].rdy <= cyc;
        chk("in_ready", io.in_ready, er);
        chk("out_valid", io.out_valid, ev);
        chk("busy", busy, q.size() != 0);
        if (ev) begin
            chk("out_tag", io.out_tag, q[0].tag);
            chk("out_result", io.out_result, q[0].res);
        end
        if (!rst_n || flush) q.delete();
        else begin
            if (ev && io.out_ready) void'(q.pop_front());
            if (io.in_valid && er)
                q.push_back('{fma_ref(io.in_a, io.in_b, io.in_c, io.in_rm, io.in_op), io.in_tag, cyc + LAT + 2});
        end
    end

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, b, c, input logic [TAGW-1:0] t);
        io.in_valid = 1;
        io.in_a = a;
        io.in_b = b;
        io.in_c = c;
        io.in_tag = t;
        io.in_rm = 3'd0;
        io.in_op = 4'd0;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, b, c, input logic [TAGW-1:0] t, input logic [31:0] exp_res);
        int lat;
        io.out_ready = 1;
        set_op(a, b, c, t);
        settle;
        chk({name, " idle before"}, busy, 0);
        adv;
        io.in_valid = 0;
        lat = 1;
        settle;
        while (!io.out_valid && lat < 20) begin
            adv;
            settle;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(LAT + 2));
        chk({name, " result"}, io.out_result, exp_res);
        chk({name, " tag"}, io.out_tag, t);
        adv;
        settle;
        chk({name, " busy after pop"}, busy, 0);
        adv;
    endtask

    typedef struct { logic [31:0] a, b, c; logic [TAGW-1:0] tag; logic [31:0] res; } vec_t;
    vec_t vt [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, exp_t;
        vt[0] = '{32'h3FC00000, 32'h40000000, 32'h3E800000, 5'd3,  32'h40500000};
        vt[1] = '{32'h40000000, 32'h40400000, 32'h3F800000, 5'd10, 32'h40E00000};
        vt[2] = '{32'hBF800000, 32'h40000000, 32'h3F000000, 5'd0,  32'hBFC00000};
        vt[3] = '{32'h40800000, 32'h3F000000, 32'hC0000000, 5'd17, 32'h00000000};
        vt[4] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 5'd31, 32'h3F800000};
        io.in_valid = 0;
        io.in_rm = 0;
        io.in_op = 0;
        io.in_a = 0;
        io.in_b = 0;
        io.in_c = 0;
        io.in_tag = 0;
        io.out_ready = 0;
        adv;
        mon_en = 1;
        settle;
        chk("in_ready during reset", io.in_ready, 0);
        adv;
        rst_n = 1;
        settle;
        chk("reset out_valid", io.out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset fma_opA", fma_opA, 0);
        chk("reset fma_rm", fma_rm, 0);
        adv;

        for (int i = 0; i < 5; i++) run_op("vec", vt[i].a, vt[i].b, vt[i].c, vt[i].tag, vt[i].res);

        io.out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            set_op(rnd(), rnd(), rnd(), 5'(i));
            settle;
            chk("b2b in_ready", io.in_ready, 1);
            adv;
        end
        io.in_valid = 0;
        repeat (LAT + 4) begin settle; adv; end
        settle;
        chk("b2b drained", busy, 0);
        adv;

        io.out_ready = 0;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            set_op(rnd(), rnd(), rnd(), 5'(i));
            settle;
            if (io.in_ready) n++;
            adv;
        end
        chk("bp fire count", 64'(n), 64'(DEPTH));
        io.in_valid = 0;
        repeat (2) begin settle; adv; end
        io.out_ready = 1;
        exp_t = 0;
        for (int i = 0; i < 12; i++) begin
            settle;
            if (i == 0) chk("bp in_ready at first pop", io.in_ready, 0);
            if (i == 1) chk("bp in_ready after first pop", io.in_ready, 1);
            if (io.out_valid) begin
                chk("bp drain tag", io.out_tag, 64'(exp_t));
                exp_t++;
            end
            adv;
        end
        chk("bp drain count", 64'(exp_t), 64'(DEPTH));

        io.out_ready = 0;
        for (int i = 0; i < 7; i++) begin set_op(rnd(), rnd(), rnd(), 5'(i)); settle; adv; end
        io.in_valid = 0;
        repeat (LAT + 3) begin settle; adv; end
        set_op(rnd(), rnd(), rnd(), 5'd7);
        io.out_ready = 1;
        settle;
        chk("occ7 fire+pop in_ready", io.in_ready, 1);
        adv;
        io.in_valid = 0;
        io.out_ready = 0;
        settle;
        chk("occ7 held in_ready", io.in_ready, 1);
        adv;
        set_op(rnd(), rnd(), rnd(), 5'd8);
        settle;
        adv;
        io.in_valid = 0;
        settle;
        chk("occ8 in_ready", io.in_ready, 0);
        adv;
        io.out_ready = 1;
        settle;
        adv;
        io.out_ready = 0;
        settle;
        chk("pop from full in_ready", io.in_ready, 1);
        adv;
        io.out_ready = 1;
        repeat (LAT + 10) begin settle; adv; end

        for (int i = 0; i < 3; i++) begin set_op(rnd(), rnd(), rnd(), 5'(20 + i)); settle; adv; end
        io.in_valid = 0;
        settle;
        adv;
        flush = 1;
        set_op(rnd(), rnd(), rnd(), 5'd29);
        settle;
        chk("flush in_ready", io.in_ready, 0);
        adv;
        flush = 0;
        run_op("post-flush", vt[1].a, vt[1].b, vt[1].c, 5'd21, vt[1].res);

        io.out_ready = 0;
        for (int i = 0; i < 2; i++) begin set_op(rnd(), rnd(), rnd(), 5'(i)); settle; adv; end
        io.in_valid = 0;
        repeat (LAT + 3) begin settle; adv; end
        for (int i = 0; i < 5; i++) begin set_op(rnd(), rnd(), rnd(), 5'(2 + i)); settle; adv; end
        io.in_valid = 0;
        rst_n = 0;
        settle;
        adv;
        rst_n = 1;
        io.out_ready = 1;
        settle;
        chk("post-reset busy", busy, 0);
        chk("post-reset fma_opA", fma_opA, 0);
        chk("post-reset fma_opB", fma_opB, 0);
        chk("post-reset fma_opC", fma_opC, 0);
        chk("post-reset fma_op", fma_op, 0);
        adv;
        repeat (LAT + 4) begin
            settle;
            chk("post-reset no output", io.out_valid, 0);
            adv;
        end
        run_op("post-reset", vt[2].a, vt[2].b, vt[2].c, 5'd9, vt[2].res);

        for (int i = 0; i < 3000; i++) begin
            io.in_valid = $urandom_range(0, 3) != 0;
            io.in_a = rnd();
            io.in_b = rnd();
            io.in_c = rnd();
            io.in_rm = 3'($urandom);
            io.in_op = 4'($urandom);
            io.in_tag = 5'($urandom);
            io.out_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush = $urandom_range(0, 79) == 0;
            rst_n = $urandom_range(0, 299) != 0;
            settle;
            adv;
        end
        flush = 0;
        rst_n = 1;
        io.in_valid = 0;
        io.out_ready = 1;
        repeat (20) begin settle; adv; end
        settle;
        chk("final busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
